// File: rtl/ysyx_22050243_scoreboard_pkg.sv
// Shared core constants for the GPR scoreboard, forwarding and decode blocks,
// plus the pending-counter update encoding.
package ysyx_22050243_scoreboard_pkg;

  localparam int CORE_GPR_ADDR_WIDTH = 5;
  localparam int CORE_NUM_GPR        = 32;
  localparam int CORE_X0_IDX         = 0;

  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_op_e;

  function automatic logic [1:0] cnt_apply(input logic [1:0] cnt, input cnt_op_e op);
    case (op)
      CNT_INC:  cnt_apply = cnt + 2'd1;
      CNT_DEC:  cnt_apply = cnt - 2'd1;
      CNT_HOLD: cnt_apply = cnt;
      default:  cnt_apply = cnt;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22050243_scoreboard_if.sv
// ID/WB hazard bundle between the pipeline top (master) and the scoreboard (slave).
interface ysyx_22050243_scoreboard_if #(
  parameter int GPR_ADDR_WIDTH = ysyx_22050243_scoreboard_pkg::CORE_GPR_ADDR_WIDTH,
  parameter int NUM_GPR        = ysyx_22050243_scoreboard_pkg::CORE_NUM_GPR
);

  logic                      id_valid;
  logic [GPR_ADDR_WIDTH-1:0] id_rs1;
  logic [GPR_ADDR_WIDTH-1:0] id_rs2;
  logic                      id_rs1_en;
  logic                      id_rs2_en;
  logic [GPR_ADDR_WIDTH-1:0] id_rd;
  logic                      id_reg_w;
  logic                      id_long;
  logic                      id_issue;
  logic                      flush;
  logic                      wb_valid;
  logic                      wb_long;
  logic                      wb_reg_w;
  logic [GPR_ADDR_WIDTH-1:0] wb_rd;
  logic                      stall_id;
  logic [NUM_GPR-1:0]        pending_vec;
  logic [1:0]                pending_cnt;
  logic                      busy;
  logic                      sb_err;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_en, id_rs2_en, id_rd, id_reg_w,
           id_long, id_issue, flush, wb_valid, wb_long, wb_reg_w, wb_rd,
    input  stall_id, pending_vec, pending_cnt, busy, sb_err
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_en, id_rs2_en, id_rd, id_reg_w,
           id_long, id_issue, flush, wb_valid, wb_long, wb_reg_w, wb_rd,
    output stall_id, pending_vec, pending_cnt, busy, sb_err
  );

endinterface

// File: rtl/ysyx_22050243_scoreboard.sv
// GPR scoreboard: tracks destinations of in-flight long-latency writes and
// stalls ID on RAW, WAW or when the outstanding-write budget is exhausted.
module ysyx_22050243_scoreboard
  import ysyx_22050243_scoreboard_pkg::*;
#(
  parameter int GPR_ADDR_WIDTH = CORE_GPR_ADDR_WIDTH,
  parameter int NUM_GPR        = CORE_NUM_GPR,
  parameter int MAX_OUTST      = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  ysyx_22050243_scoreboard_if.slave    sb
);

  localparam logic [GPR_ADDR_WIDTH-1:0] X0      = GPR_ADDR_WIDTH'(CORE_X0_IDX);
  localparam logic [1:0]                MAX_CNT = 2'(MAX_OUTST);

  logic [NUM_GPR-1:0] pending_r;
  logic [1:0]         cnt_r;
  logic               busy_r;
  logic               err_r;

  logic               raw1_s;
  logic               raw2_s;
  logic               waw_s;
  logic               cap_s;
  logic               stall_s;
  logic               issue_set_s;
  logic               wb_clr_s;
  logic               set_ok_s;
  logic               clr_ok_s;
  cnt_op_e            cnt_op_s;
  logic [NUM_GPR-1:0] pending_nxt_s;
  logic [1:0]         cnt_nxt_s;
  logic               err_nxt_s;

  // Hazard compare against registered state only, so a same-cycle clear never hides a stall.
  always_comb begin
    raw1_s  = sb.id_rs1_en & (sb.id_rs1 != X0) & pending_r[sb.id_rs1];
    raw2_s  = sb.id_rs2_en & (sb.id_rs2 != X0) & pending_r[sb.id_rs2];
    waw_s   = sb.id_reg_w  & (sb.id_rd  != X0) & pending_r[sb.id_rd];
    cap_s   = sb.id_long   & (cnt_r == MAX_CNT);
    stall_s = sb.id_valid  & (raw1_s | raw2_s | waw_s | cap_s);
  end

  // Qualify issue and writeback events; illegal ones are dropped and only flag an error.
  always_comb begin
    issue_set_s = sb.id_valid & sb.id_issue & ~sb.flush & sb.id_reg_w & sb.id_long
                & (sb.id_rd != X0);
    wb_clr_s    = sb.wb_valid & sb.wb_long & sb.wb_reg_w & (sb.wb_rd != X0);
    set_ok_s    = issue_set_s & ~stall_s;
    clr_ok_s    = wb_clr_s & pending_r[sb.wb_rd] & (cnt_r != 2'd0);
    err_nxt_s   = err_r | (issue_set_s & stall_s) | (wb_clr_s & ~clr_ok_s);
  end

  // Next pending vector and counter; set and clear on different registers both apply.
  always_comb begin
    pending_nxt_s = pending_r;
    if (clr_ok_s) begin
      pending_nxt_s[sb.wb_rd] = 1'b0;
    end else begin
      pending_nxt_s = pending_nxt_s;
    end
    if (set_ok_s) begin
      pending_nxt_s[sb.id_rd] = 1'b1;
    end else begin
      pending_nxt_s = pending_nxt_s;
    end
    pending_nxt_s[0] = 1'b0;

    case ({set_ok_s, clr_ok_s})
      2'b10:   cnt_op_s = CNT_INC;
      2'b01:   cnt_op_s = CNT_DEC;
      default: cnt_op_s = CNT_HOLD;
    endcase
    cnt_nxt_s = cnt_apply(cnt_r, cnt_op_s);
  end

  // Scoreboard state; reset overrides any same-cycle issue or writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_r <= '0;
      cnt_r     <= 2'd0;
      busy_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      pending_r <= pending_nxt_s;
      cnt_r     <= cnt_nxt_s;
      busy_r    <= (cnt_nxt_s != 2'd0);
      err_r     <= err_nxt_s;
    end
  end

  assign sb.stall_id    = stall_s;
  assign sb.pending_vec = pending_r;
  assign sb.pending_cnt = cnt_r;
  assign sb.busy        = busy_r;
  assign sb.sb_err      = err_r;

endmodule

// File: tb/tb_ysyx_22050243_scoreboard.sv
// Table-driven bench for the GPR scoreboard: each row drives one cycle, checks
// stall_id before the edge and queues the post-edge state for comparison.
module tb_ysyx_22050243_scoreboard;

  logic clk;
  logic rst;

  ysyx_22050243_scoreboard_if sb_if ();

  ysyx_22050243_scoreboard #(
    .GPR_ADDR_WIDTH(5),
    .NUM_GPR       (32),
    .MAX_OUTST     (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sb (sb_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [4:0]  rs1;
    logic        e1;
    logic [4:0]  rs2;
    logic        e2;
    logic [4:0]  rd;
    logic        w;
    logic        lng;
    logic        iss;
    logic        fl;
    logic        wbv;
    logic        wbl;
    logic [4:0]  wbrd;
    logic        st;
    logic [31:0] vec;
    logic [1:0]  cnt;
    logic        err;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input int v, input int rs1, input int e1, input int rs2,
                              input int e2, input int rd, input int w, input int lng,
                              input int iss, input int fl, input int wbv, input int wbl,
                              input int wbrd, input int st, input logic [31:0] vec,
                              input int cnt, input int err);
    vec_t r;
    r.v = (v != 0);     r.rs1 = 5'(rs1);   r.e1 = (e1 != 0);
    r.rs2 = 5'(rs2);    r.e2 = (e2 != 0);  r.rd = 5'(rd);
    r.w = (w != 0);     r.lng = (lng != 0); r.iss = (iss != 0);
    r.fl = (fl != 0);   r.wbv = (wbv != 0); r.wbl = (wbl != 0);
    r.wbrd = 5'(wbrd);  r.st = (st != 0);  r.vec = vec;
    r.cnt = 2'(cnt);    r.err = (err != 0);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    sb_if.id_valid  = t.v;
    sb_if.id_rs1    = t.rs1;
    sb_if.id_rs1_en = t.e1;
    sb_if.id_rs2    = t.rs2;
    sb_if.id_rs2_en = t.e2;
    sb_if.id_rd     = t.rd;
    sb_if.id_reg_w  = t.w;
    sb_if.id_long   = t.lng;
    sb_if.id_issue  = t.iss;
    sb_if.flush     = t.fl;
    sb_if.wb_valid  = t.wbv;
    sb_if.wb_long   = t.wbl;
    sb_if.wb_reg_w  = t.wbv;
    sb_if.wb_rd     = t.wbrd;
  endtask

  task automatic check_state(input string name, input vec_t e);
    chk({name, ".vec"},  sb_if.pending_vec, e.vec);
    chk({name, ".cnt"},  32'(sb_if.pending_cnt), 32'(e.cnt));
    chk({name, ".busy"}, 32'(sb_if.busy), 32'(e.cnt != 2'd0));
    chk({name, ".err"},  32'(sb_if.sb_err), 32'(e.err));
  endtask

  // One cycle: called just after a rising edge; returns just after the next one.
  task automatic step(input string name, input vec_t t);
    vec_t e;
    drive(t);
    #3;
    chk({name, ".stall"}, 32'(sb_if.stall_id), 32'(t.st));
    exp_q.push_back(t);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_state(name, e);
  endtask

  task automatic pulse_reset(input vec_t t);
    drive(t);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t idle;
    idle = mk(0,0,0,0,0,0,0,0,0,0, 0,0,0, 0, 32'h0,0,0);
    rst = 1'b1;
    drive(idle);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_state("reset", idle);
    chk("reset.stall", 32'(sb_if.stall_id), 32'd0);

    // v rs1 e1 rs2 e2 rd w lng iss fl | wbv wbl wbrd | st vec cnt err
    tbl.push_back(mk(1,0,0,0,0, 5,1,1,1,0, 0,0,0,  0, 32'h0000_0020,1,0)); // issue x5
    tbl.push_back(mk(1,5,1,0,0, 0,0,0,0,0, 0,0,0,  1, 32'h0000_0020,1,0)); // load-use
    tbl.push_back(mk(1,5,1,0,0, 0,0,0,0,0, 1,1,5,  1, 32'h0000_0000,0,0)); // clr not yet visible
    tbl.push_back(mk(1,5,1,0,0, 0,0,0,0,0, 0,0,0,  0, 32'h0000_0000,0,0));
    tbl.push_back(mk(1,0,0,0,0, 7,1,1,1,0, 0,0,0,  0, 32'h0000_0080,1,0)); // issue x7
    tbl.push_back(mk(1,0,0,0,0, 7,1,0,0,0, 0,0,0,  1, 32'h0000_0080,1,0)); // WAW
    tbl.push_back(mk(1,0,0,0,0, 7,1,0,0,0, 1,1,7,  1, 32'h0000_0000,0,0));
    tbl.push_back(mk(1,0,0,0,0, 7,1,0,1,0, 0,0,0,  0, 32'h0000_0000,0,0)); // short issue
    tbl.push_back(mk(1,0,0,0,0, 3,1,1,1,0, 0,0,0,  0, 32'h0000_0008,1,0)); // issue x3
    tbl.push_back(mk(1,0,0,0,0, 4,1,1,1,0, 0,0,0,  0, 32'h0000_0018,2,0)); // issue x4
    tbl.push_back(mk(1,0,0,0,0, 9,1,1,0,0, 0,0,0,  1, 32'h0000_0018,2,0)); // capacity
    tbl.push_back(mk(1,0,0,0,0, 9,1,1,0,0, 1,1,3,  1, 32'h0000_0010,1,0));
    tbl.push_back(mk(1,0,0,0,0, 9,1,1,1,0, 0,0,0,  0, 32'h0000_0210,2,0)); // issue x9
    tbl.push_back(mk(1,0,1,0,0,12,1,0,1,0, 0,0,0,  0, 32'h0000_0210,2,0)); // short at cap
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 1,1,4,  0, 32'h0000_0200,1,0));
    tbl.push_back(mk(1,0,0,0,0,11,1,1,1,0, 1,1,9,  0, 32'h0000_0800,1,0)); // set+clr
    tbl.push_back(mk(1,0,0,0,0, 0,1,1,1,0, 0,0,0,  0, 32'h0000_0800,1,0)); // x0 dest
    tbl.push_back(mk(1,0,0,0,0, 6,1,1,1,1, 0,0,0,  0, 32'h0000_0800,1,0)); // flushed
    tbl.push_back(mk(1,0,1,11,0,0,0,0,0,0, 0,0,0,  0, 32'h0000_0800,1,0)); // rs2 not read
    tbl.push_back(mk(1,0,0,11,1,0,0,0,0,0, 0,0,0,  1, 32'h0000_0800,1,0)); // RAW rs2
    tbl.push_back(mk(0,0,0,11,1,0,0,0,0,0, 0,0,0,  0, 32'h0000_0800,1,0)); // not valid
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 1,0,11, 0, 32'h0000_0800,1,0)); // wb not long
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 1,1,11, 0, 32'h0000_0000,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 1,1,10, 0, 32'h0000_0000,0,1)); // clr at cnt 0
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0,  0, 32'h0000_0000,0,1)); // sticky
    tbl.push_back(mk(1,0,0,0,0, 3,1,1,1,0, 0,0,0,  0, 32'h0000_0008,1,1)); // issue x3
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 1,1,0,  0, 32'h0000_0008,1,1)); // wb x0 ignored

    for (int i = 0; i < tbl.size(); i++) begin
      step($sformatf("row%0d", i), tbl[i]);
    end

    // Reset with x3 in flight and an issue of x8 in the same cycle.
    pulse_reset(mk(1,0,0,0,0, 8,1,1,1,0, 1,1,3, 0, 32'h0,0,0));
    check_state("rst1", idle);
    step("rst1_use", mk(1,3,1,0,0, 0,0,0,0,0, 0,0,0, 0, 32'h0,0,0));

    // Issue attempted while stalled: dropped and flagged.
    step("ovr_iss",  mk(1,0,0,0,0, 5,1,1,1,0, 0,0,0, 0, 32'h0000_0020,1,0));
    step("ovr_bad",  mk(1,5,1,0,0,13,1,1,1,0, 0,0,0, 1, 32'h0000_0020,1,1));
    step("ovr_clr",  mk(0,0,0,0,0, 0,0,0,0,0, 1,1,5, 0, 32'h0000_0000,0,1));

    // Clear of a non-pending register while another write is in flight.
    pulse_reset(idle);
    check_state("rst2", idle);
    step("np_iss",   mk(1,0,0,0,0, 5,1,1,1,0, 0,0,0, 0, 32'h0000_0020,1,0));
    step("np_clr",   mk(0,0,0,0,0, 0,0,0,0,0, 1,1,10, 0, 32'h0000_0020,1,1));
    step("np_hold",  mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0, 0, 32'h0000_0020,1,1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
